cnt_ctrl: RTL and testbench
===========================

Name: cnt_ctrl

Overview:
- Control front-end placed directly upstream of the 4-bit counter.
- Turns two raw push-button inputs (run/pause and clear) into clean single-cycle control: a periodic `en` tick and a one-cycle `clr` pulse.
- Its `en` and `clr` outputs connect straight to the counter's `en`/`clr` inputs.
- Contains a 2-flop synchroniser, debouncer and edge detector per button, a run/pause toggle, and a programmable tick divider.

Parameters:
- DB_CYCLES, 4, consecutive cycles a synchronised button level must be stable before the debounced level changes (>=1).
- DIV, 10, tick period in clock cycles; `en` fires once every DIV cycles while running (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_run  input  1  raw run/pause button, asynchronous to clk, may bounce.
- btn_clr  input  1  raw clear button, asynchronous to clk, may bounce.
- en  output  1  registered count-enable tick to the counter.
- clr  output  1  registered one-cycle clear pulse to the counter.
- running  output  1  registered run/pause state.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. While reset=1, every register clears immediately without waiting for a clock edge:
  - en=0, clr=0, running=0;
  - synchroniser flops=0, debounced levels=0, debounce counters=0, divider=0.
- Synchroniser: each button passes through s1 then s2, two flops.
- Debouncer, per button:
  - If s2 equals the debounced level, the counter resets to 0.
  - Otherwise the counter increments each edge.
  - On the edge where the counter equals DB_CYCLES-1 and s2 still differs, the debounced level takes s2 and the counter resets to 0.
  - Any return of s2 to the old level before that edge discards the count, so glitches shorter than DB_CYCLES cycles are ignored.
- Rise event: generated on the edge where a debounced level goes 0->1. There is no fall event and no auto-repeat while a button is held.
- Latency: btn_run first sampled high at edge t and held high gives a rise at edge t+DB_CYCLES+1, so running toggles at that edge. The same latency applies to clr.
- Run/pause: a btn_run rise toggles `running`.
- Divider: width $clog2(DIV), min 1 bit.
  - While running=1 (pre-edge value): div <= (div==DIV-1) ? 0 : div+1, and en <= (div==DIV-1).
  - While running=0: div holds and en <= 0.
  - The first en after a pause->run toggle at edge R is registered at edge R+DIV. en stays high for exactly one cycle, then repeats every DIV cycles.
  - DIV=1: en=1 every cycle while running, starting from edge R+1.
  - Pausing mid-period preserves div, so resuming completes the remaining period.
- Clear: a btn_clr rise sets clr <= 1 for exactly one cycle. On the same edge div <= 0 and en <= 0, which override divider wrap. running is unaffected.
- Simultaneous rises of run and clr on one edge: running toggles, clr pulses, div <= 0, en <= 0.
- Guarantees:
  - en and clr are never both 1 in the same cycle.
  - Outputs are glitch-free because they are registered.
- Reset asserted mid-period or mid-debounce: all progress is lost. After release, buttons already held high are treated as new presses and debounced again.

Test Plan:
- Reset with DB_CYCLES=4, DIV=10: assert reset mid-cycle -> en, clr, running drop to 0 immediately, before any edge. Release, run 20 cycles -> all stay 0.
- Clean run press: btn_run 0->1 sampled at edge t and held -> running=1 from edge t+5. en pulses exactly one cycle at edges t+15, t+25, t+35. Holding the button causes no further toggles.
- Bounce rejection: btn_run toggles high/low with 1-3 cycle pulses for 30 cycles, then stays low -> running never changes, en stays 0. Follow with a stable 3-cycle high pulse -> still ignored. A stable 4-cycle-plus high -> one toggle.
- Pause/resume: run, pause when div=6 (press second time), wait 50 cycles -> no en during pause. Resume at edge R -> first en at edge R+4 (remaining period), then every 10 cycles.
- Clear: while running, btn_clr rise registered at edge c -> clr=1 for one cycle after edge c only, en=0 that cycle. Next en at edge c+10. Connected counter reads 0 then 1.
- Simultaneous and DIV=1: presses aligned so both rises land on the same edge while paused -> running=1, clr pulse, no en that cycle. Separately, DIV=1 running -> en high every cycle, counter wraps 15->0 every 16 cycles.

Source files
------------

// File: rtl/cnt_ctrl.sv
// Push-button control front-end for the 4-bit counter: synchronises and debounces
// run/pause and clear buttons, then produces a periodic en tick and a one-cycle clr pulse.

// One button lane: 2-flop synchroniser, stability-count debouncer, 0->1 edge detect.
module cnt_ctrl_btn #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          settle;

    // The debounced level flips on the edge that completes DB_CYCLES stable samples.
    assign settle = (s2 != level) && (cnt == CNT_LAST);
    assign rise   = settle && s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module cnt_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int DIV       = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_clr,
    output logic en,
    output logic clr,
    output logic running
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          run_rise;
    logic          clr_rise;
    logic [DW-1:0] div;

    cnt_ctrl_btn #(.DB_CYCLES(DB_CYCLES)) u_run (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_run),
        .rise  (run_rise)
    );

    cnt_ctrl_btn #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clr),
        .rise  (clr_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            en      <= 1'b0;
            clr     <= 1'b0;
            div     <= '0;
        end else begin
            if (run_rise) begin
                running <= ~running;
            end
            // A clear restarts the tick period and wins over a divider wrap.
            if (clr_rise) begin
                clr <= 1'b1;
                en  <= 1'b0;
                div <= '0;
            end else begin
                clr <= 1'b0;
                if (running) begin
                    en  <= (div == DIV_LAST);
                    div <= (div == DIV_LAST) ? '0 : div + 1'b1;
                end else begin
                    en <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: table-driven per-cycle vectors through an
// expected-output queue, plus hand sequences for bounce, async reset and DIV=1.
module tb_cnt_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_run = 1'b0;
    logic btn_clr = 1'b0;
    logic en, clr, running;

    logic run1 = 1'b0;
    logic clrb1 = 1'b0;
    logic en1, clr1, running1;
    logic [3:0] cnt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic r;
        logic c;
        int   n;
        logic ee;
        logic ec;
        logic er;
    } vec_t;
    vec_t tbl[$];

    cnt_ctrl #(.DB_CYCLES(4), .DIV(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_run (btn_run),
        .btn_clr (btn_clr),
        .en      (en),
        .clr     (clr),
        .running (running)
    );

    cnt_ctrl #(.DB_CYCLES(4), .DIV(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .btn_run (run1),
        .btn_clr (clrb1),
        .en      (en1),
        .clr     (clr1),
        .running (running1)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // downstream 4-bit counter fed by the DIV=1 instance
    always @(posedge clk or posedge reset) begin
        if (reset) cnt1 <= 4'd0;
        else if (clr1) cnt1 <= 4'd0;
        else if (en1) cnt1 <= cnt1 + 4'd1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        run1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        logic [2:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            if ({en, clr, running} !== e) begin
                failures++;
                $display("FAIL %s cyc=%0d {en,clr,running} got=%b exp=%b",
                         tag, cyc, {en, clr, running}, e);
            end
        end
    endtask

    // Drive buttons for n cycles; outputs after each edge must equal the expectation.
    task automatic apply(input string tag, input logic r, input logic c, input int n,
                         input logic ee, input logic ec, input logic er);
        for (int k = 0; k < n; k++) begin
            btn_run = r;
            btn_clr = c;
            exp_q.push_back({ee, ec, er});
            @(posedge clk);
            @(negedge clk);
            check_out(tag);
        end
    endtask

    task automatic add(input logic r, input logic c, input int n,
                       input logic ee, input logic ec, input logic er);
        vec_t v;
        v.r = r; v.c = c; v.n = n; v.ee = ee; v.ec = ec; v.er = er;
        tbl.push_back(v);
    endtask

    initial begin
        // idle, clean press (edge t), en at t+15/t+25/t+35
        add(0, 0, 20, 0, 0, 0);
        add(1, 0, 5,  0, 0, 0);
        add(1, 0, 10, 0, 0, 1);
        add(1, 0, 1,  1, 0, 1);
        add(1, 0, 9,  0, 0, 1);
        add(1, 0, 1,  1, 0, 1);
        add(0, 0, 9,  0, 0, 1);
        add(0, 0, 1,  1, 0, 1);
        // pause landing with div=6, 50 idle cycles, resume at R -> en at R+4
        add(1, 0, 5,  0, 0, 1);
        add(1, 0, 1,  0, 0, 0);
        add(0, 0, 50, 0, 0, 0);
        add(1, 0, 5,  0, 0, 0);
        add(1, 0, 1,  0, 0, 1);
        add(1, 0, 3,  0, 0, 1);
        add(1, 0, 1,  1, 0, 1);
        add(0, 0, 9,  0, 0, 1);
        add(0, 0, 1,  1, 0, 1);
        // clear rise at c coincides with divider wrap; next en at c+10, c+20
        add(0, 0, 4,  0, 0, 1);
        add(0, 1, 5,  0, 0, 1);
        add(0, 1, 1,  0, 1, 1);
        add(0, 1, 3,  0, 0, 1);
        add(0, 0, 6,  0, 0, 1);
        add(0, 0, 1,  1, 0, 1);
        add(0, 0, 9,  0, 0, 1);
        add(0, 0, 1,  1, 0, 1);

        do_reset();
        apply("idle", 0, 0, 20, 0, 0, 0);

        // bounce: high pulses of 1-3 cycles never toggle
        for (int used = 0; used < 30; ) begin
            int hi, lo;
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 3);
            apply("bounce", 1, 0, hi, 0, 0, 0);
            apply("bounce", 0, 0, lo, 0, 0, 0);
            used += hi + lo;
        end
        apply("bounce_low", 0, 0, 6, 0, 0, 0);
        apply("pulse3", 1, 0, 3, 0, 0, 0);
        apply("pulse3", 0, 0, 8, 0, 0, 0);
        apply("pulse4", 1, 0, 4, 0, 0, 0);
        apply("pulse4", 0, 0, 1, 0, 0, 0);
        apply("pulse4_run", 0, 0, 5, 0, 0, 1);

        // asynchronous reset between edges while running
        #2 reset = 1'b1;
        #1 chk("async_reset", int'({en, clr, running}), 0);
        @(negedge clk);
        reset = 1'b0;
        apply("post_reset", 0, 0, 20, 0, 0, 0);
        do_reset();

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i].r, tbl[i].c, tbl[i].n,
                               tbl[i].ee, tbl[i].ec, tbl[i].er);

        // simultaneous run and clr rises while paused
        do_reset();
        apply("simul", 0, 0, 3, 0, 0, 0);
        apply("simul", 1, 1, 5, 0, 0, 0);
        apply("simul_edge", 1, 1, 1, 0, 1, 1);
        apply("simul_after", 0, 0, 9, 0, 0, 1);
        apply("simul_en", 0, 0, 1, 1, 0, 1);

        // DIV=1: en every cycle, downstream counter wraps every 16
        do_reset();
        run1 = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("div1_wait", int'(running1), 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("div1_run", int'({running1, en1}), 2);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("div1_en", int'({en1, clr1}), 2);
            chk("div1_cnt", int'(cnt1), k % 16);
        end
        run1 = 1'b0;

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
